usr_shift_controller: RTL and testbench
=======================================

// Module: usr_shift_controller
// PURPOSE
//  Sequencer for the 4-bit universal shift register (mux4to1 + d_ff datapath).
//  Accepts one command per handshake: parallel word, direction, shift count, fill bit.
//  Drives the register's sel_line/in/msb_in/lsb_in to load, then shift N times.
//  Streams out each departing bit, then presents the final register contents to the consumer.
// PARAMETERS
//  WIDTH  4  register width; must match the shift register instance
//  CNT_W  3  width of the shift-count field; max shift = 2**CNT_W-1
// PORTS
//  CLK           in   1      system clock, rising edge
//  Clear_b       in   1      async active-low reset; also drives the register's Clear_b
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      controller can accept a command
//  cmd_data      in   WIDTH  parallel word to load
//  cmd_dir       in   1      0 = shift right (toward bit0), 1 = shift left
//  cmd_count     in   CNT_W  number of shift cycles after the load
//  cmd_fill      in   1      serial bit inserted at the vacated end
//  abort         in   1      synchronous abort of the running command
//  sel_line      out  2      to register: 00 hold, 01 right, 10 left, 11 load
//  par_out       out  WIDTH  to register parallel input (the latched cmd_data)
//  msb_in        out  1      to register; = latched fill when dir=0, else 0
//  lsb_in        out  1      to register; = latched fill when dir=1, else 0
//  reg_q         in   WIDTH  register output feedback
//  ser_valid     out  1      high during every SHIFT cycle
//  ser_out       out  1      bit leaving: reg_q[0] (right) / reg_q[WIDTH-1] (left)
//  res_valid     out  1      final contents available
//  res_ready     in   1      consumer accepts the result
//  res_data      out  WIDTH  = reg_q while res_valid
// BEHAVIOUR
//  - Reset (Clear_b=0, async): state=IDLE; cmd_ready=1; sel_line=00.
//    par_out, msb_in, lsb_in, ser_valid, res_valid all 0; counter 0.
//  - Registered FSM. Outputs are decoded from the state register and the latched command.
//  - IDLE: cmd_ready=1, sel=00. On cmd_valid&cmd_ready, latch data/dir/count/fill; next state LOAD.
//  - LOAD (1 cycle): sel=11 and par_out=latched data. The register holds the data after this edge.
//    Next state is SHIFT if count!=0, else DONE.
//  - SHIFT: sel=01 (dir=0) or 10 (dir=1). ser_valid=1; ser_out is taken from the pre-edge reg_q.
//    The counter decrements each cycle. Exactly count SHIFT cycles, then DONE.
//  - DONE: sel=00, res_valid=1, res_data=reg_q. Holds until res_ready.
//    On res_valid&res_ready the next state is IDLE. No new command is accepted in the same cycle.
//  - cmd_ready is 1 only in IDLE. Command latency: accept edge +1 (LOAD) +count +1 gives res_valid.
//  - abort=1 in LOAD/SHIFT/DONE: next state IDLE with sel=00 and no res_valid. The register keeps its partial value.
//    abort in IDLE has no effect. abort wins over cmd_valid and res_ready in the same cycle.
//  - msb_in/lsb_in are driven from latched fill in all non-IDLE states and are 0 in IDLE.
//  - Reset asserted mid-command returns to IDLE immediately. Register and controller clear together.
// TESTING
//  1 data=1011,dir=0,count=2,fill=0 -> reg 1011,0101,0010; ser_out 1,1; res_data=0010 at 4th cycle after accept
//  2 data=0001,dir=1,count=3,fill=1 -> reg 0011,0111,1111; ser_out 0,0,0; res_data=1111
//  3 count=0,data=1100 -> LOAD then DONE; ser_valid never high; res_data=1100 two cycles after accept
//  4 res_ready held low 5 cycles in DONE -> sel stays 00, res_data stable, cmd_ready=0 and a new cmd_valid is ignored
//  5 abort during 2nd SHIFT of count=5 -> IDLE next cycle, no res_valid, cmd_ready=1, reg holds partial value
//  6 Clear_b pulsed low mid-SHIFT -> outputs reset asynchronously, reg_q=0000, new command completes normally

Source files
------------

// File: rtl/usr_shift_controller.sv
// Sequencer for a universal shift register: load, shift N times, stream departing bits, hand off result.
// Latency accept +1 (load) +count +1 to res_valid; cmd_ready only in IDLE, DONE holds until res_ready.
module usr_shift_controller #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             CLK,
   input  logic             Clear_b,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_fill,
   input  logic             abort,
   output logic [1:0]       sel_line,
   output logic [WIDTH-1:0] par_out,
   output logic             msb_in,
   output logic             lsb_in,
   input  logic [WIDTH-1:0] reg_q,
   output logic             ser_valid,
   output logic             ser_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_RIGHT = 2'b01;
   localparam logic [1:0] SEL_LEFT  = 2'b10;
   localparam logic [1:0] SEL_LOAD  = 2'b11;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               dir_q, dir_d;
   logic               fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge CLK or negedge Clear_b) begin
      if (!Clear_b) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         dir_q   <= 1'b0;
         fill_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q holds the number of shift cycles still to perform, including the current one
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dir_d   = dir_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               data_d  = cmd_data;
               dir_d   = cmd_dir;
               fill_d  = cmd_fill;
               cnt_d   = cmd_count;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (abort || res_ready) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Moore decode: register control comes only from state and the latched command
   always_comb begin
      cmd_ready = 1'b0;
      sel_line  = SEL_HOLD;
      ser_valid = 1'b0;
      ser_out   = 1'b0;
      res_valid = 1'b0;
      res_data  = '0;
      msb_in    = 1'b0;
      lsb_in    = 1'b0;
      par_out   = data_q;
      if (state_q != S_IDLE) begin
         msb_in = fill_q & ~dir_q;
         lsb_in = fill_q & dir_q;
      end
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
         end
         S_LOAD: begin
            sel_line = SEL_LOAD;
         end
         S_SHIFT: begin
            sel_line  = dir_q ? SEL_LEFT : SEL_RIGHT;
            ser_valid = 1'b1;
            ser_out   = dir_q ? reg_q[WIDTH-1] : reg_q[0];
         end
         S_DONE: begin
            res_valid = 1'b1;
            res_data  = reg_q;
         end
         default: begin
            sel_line = SEL_HOLD;
         end
      endcase
   end

endmodule

// File: tb/tb_usr_shift_controller.sv
// Bench for usr_shift_controller: a behavioural shift register closes the loop, a shift-arithmetic model predicts results.
module tb_usr_shift_controller;

   logic       CLK;
   logic       Clear_b;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_data;
   logic       cmd_dir;
   logic [2:0] cmd_count;
   logic       cmd_fill;
   logic       abort;
   logic [1:0] sel_line;
   logic [3:0] par_out;
   logic       msb_in;
   logic       lsb_in;
   logic [3:0] reg_q;
   logic       ser_valid;
   logic       ser_out;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;

   int n_checks;
   int n_pass;

   usr_shift_controller #(.WIDTH(4), .CNT_W(3)) dut (
      .CLK(CLK), .Clear_b(Clear_b),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
      .abort(abort), .sel_line(sel_line), .par_out(par_out),
      .msb_in(msb_in), .lsb_in(lsb_in), .reg_q(reg_q),
      .ser_valid(ser_valid), .ser_out(ser_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // external 4-bit universal shift register, cleared together with the controller
   always_ff @(posedge CLK or negedge Clear_b) begin
      if (!Clear_b) reg_q <= 4'b0000;
      else begin
         case (sel_line)
            2'b01:   reg_q <= {msb_in, reg_q[3:1]};
            2'b10:   reg_q <= {reg_q[2:0], lsb_in};
            2'b11:   reg_q <= par_out;
            default: reg_q <= reg_q;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // one shift step of the reference model on a plain integer value
   function automatic int shift_once(input int v, input int dir, input int fill);
      if (dir != 0) return ((v * 2) % 16) + fill;
      return (v / 2) + fill * 8;
   endfunction

   function automatic int leaving_bit(input int v, input int dir);
      if (dir != 0) return (v / 8) % 2;
      return v % 2;
   endfunction

   task automatic run_cmd(input int data, input int dir, input int count, input int fill,
                          input int hold, input int abort_at, input int rst_at, input int abort_idle);
      int v;
      @(negedge CLK);
      check("idle_ready", cmd_ready, 1);
      check("idle_sel", sel_line, 0);
      cmd_valid = 1'b1;
      cmd_data  = 4'(data);
      cmd_dir   = 1'(dir);
      cmd_count = 3'(count);
      cmd_fill  = 1'(fill);
      abort     = 1'(abort_idle);
      @(negedge CLK);
      cmd_valid = 1'b0;
      abort     = 1'b0;
      cmd_data  = 4'($urandom);
      cmd_dir   = 1'($urandom);
      cmd_count = 3'($urandom);
      cmd_fill  = 1'($urandom);
      check("load_sel", sel_line, 3);
      check("load_par", par_out, data);
      check("load_ready", cmd_ready, 0);
      check("load_ser_valid", ser_valid, 0);
      check("load_msb", msb_in, (dir == 0) ? fill : 0);
      check("load_lsb", lsb_in, (dir != 0) ? fill : 0);
      v = data;
      for (int k = 0; k < count; k++) begin
         @(negedge CLK);
         check("shift_ser_valid", ser_valid, 1);
         check("shift_sel", sel_line, (dir != 0) ? 2 : 1);
         check("shift_reg", reg_q, v);
         check("shift_ser_out", ser_out, leaving_bit(v, dir));
         v = shift_once(v, dir, fill);
         if (k == rst_at) begin
            Clear_b = 1'b0;
            #1;
            check("rst_ready", cmd_ready, 1);
            check("rst_sel", sel_line, 0);
            check("rst_reg", reg_q, 0);
            check("rst_ser_valid", ser_valid, 0);
            check("rst_res_valid", res_valid, 0);
            check("rst_par", par_out, 0);
            check("rst_msb_lsb", {msb_in, lsb_in}, 0);
            @(negedge CLK);
            Clear_b = 1'b1;
            return;
         end
         if (k == abort_at) begin
            abort = 1'b1;
            @(negedge CLK);
            abort = 1'b0;
            check("abort_ready", cmd_ready, 1);
            check("abort_res_valid", res_valid, 0);
            check("abort_sel", sel_line, 0);
            check("abort_reg", reg_q, v);
            return;
         end
      end
      @(negedge CLK);
      check("done_res_valid", res_valid, 1);
      check("done_res_data", res_data, v);
      check("done_sel", sel_line, 0);
      check("done_ready", cmd_ready, 0);
      check("done_ser_valid", ser_valid, 0);
      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1'b1;
         cmd_data  = 4'($urandom);
         res_ready = 1'b0;
         @(negedge CLK);
         check("hold_res_valid", res_valid, 1);
         check("hold_res_data", res_data, v);
         check("hold_sel", sel_line, 0);
         check("hold_ready", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge CLK);
      res_ready = 1'b0;
      check("post_ready", cmd_ready, 1);
      check("post_res_valid", res_valid, 0);
      check("post_sel", sel_line, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end expected end");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, ab;
      n_checks  = 0;
      n_pass    = 0;
      Clear_b   = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = 4'h0;
      cmd_dir   = 1'b0;
      cmd_count = 3'd0;
      cmd_fill  = 1'b0;
      abort     = 1'b0;
      res_ready = 1'b0;
      #1;
      check("reset_ready", cmd_ready, 1);
      check("reset_sel", sel_line, 0);
      check("reset_par", par_out, 0);
      check("reset_msb_lsb", {msb_in, lsb_in}, 0);
      check("reset_ser_valid", ser_valid, 0);
      check("reset_res_valid", res_valid, 0);
      @(negedge CLK);
      @(negedge CLK);
      Clear_b = 1'b1;

      run_cmd(4'b1011, 0, 2, 0, 0, -1, -1, 0);
      run_cmd(4'b0001, 1, 3, 1, 0, -1, -1, 0);
      run_cmd(4'b1100, 0, 0, 0, 0, -1, -1, 0);
      run_cmd(4'b0110, 1, 1, 0, 5, -1, -1, 0);
      run_cmd(4'b1001, 0, 5, 1, 0, 1, -1, 0);
      run_cmd(4'b0111, 1, 7, 0, 0, -1, -1, 1);
      run_cmd(4'b1110, 0, 4, 1, 0, -1, 1, 0);
      run_cmd(4'b0101, 1, 6, 1, 1, -1, -1, 0);

      for (int i = 0; i < 40; i++) begin
         cnt = int'($urandom_range(0, 7));
         ab  = (cnt > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
         run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), cnt,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), ab, -1,
                 int'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
